// File: rtl/spi_esclavo_if.sv
// Word-level handshake between spi_esclavo and its local user: tx load strobe,
// rx delivery strobe, status and error flags.
interface spi_esclavo_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] tx_data_i;
   logic                  tx_valid_i;
   logic                  tx_ready_o;
   logic [DATA_WIDTH-1:0] rx_data_o;
   logic                  rx_valid_o;
   logic                  busy_o;
   logic [1:0]            err_o;
   logic                  err_clr_i;

   modport slave (
      input  tx_data_i, tx_valid_i, err_clr_i,
      output tx_ready_o, rx_data_o, rx_valid_o, busy_o, err_o
   );

   modport master (
      output tx_data_i, tx_valid_i, err_clr_i,
      input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/spi_esclavo.sv
// Mode-0 SPI slave; SCK/SS/MOSI are oversampled on spi_clk_i, nothing runs on SCK.
// Define SPI_ESCLAVO_ERRFLAG_EN to build the sticky underrun/abort flags on err_o.
module spi_esclavo #(
   parameter int DATA_WIDTH = 8
) (
   input  logic         spi_clk_i,
   input  logic         spi_rst_i,
   input  logic         SCK_SPI,
   input  logic         SS,
   input  logic         MOSI,
   output logic         MISO,
   output logic         miso_oe_o,
   input  logic         spi_fbo_i,
   spi_esclavo_if.slave bus
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t                state_q, state_d;
   logic [2:0]            sck_q, ss_q;
   logic [1:0]            mosi_q;
   logic                  sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
   logic                  fbo_q, fbo_d;
   logic                  miso_q, miso_d;
   logic                  oe_q, oe_d;
   logic                  busy_q, busy_d;
   logic                  reload_q, reload_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [DATA_WIDTH-1:0] tx_word;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  underrun, abort;

   // SS sync resets low so a select held across reset does not start a frame.
   always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
      if (!spi_rst_i) begin
         sck_q  <= '0;
         ss_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], SCK_SPI};
         ss_q   <= {ss_q[1:0], SS};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ss_rise  = ss_q[1] & ~ss_q[2];
   assign ss_fall  = ~ss_q[1] & ss_q[2];
   assign mosi_s   = mosi_q[1];

   always_comb begin
      state_d    = state_q;
      fbo_d      = fbo_q;
      miso_d     = miso_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      reload_d   = reload_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      bit_cnt_d  = bit_cnt_q;
      underrun   = 1'b0;
      abort      = 1'b0;
      tx_word    = bus.tx_valid_i ? bus.tx_data_i : '1;
      unique case (state_q)
         IDLE: begin
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            reload_d  = 1'b0;
            bit_cnt_d = '0;
            if (ss_fall) begin
               fbo_d   = spi_fbo_i;
               state_d = LOAD;
            end
         end
         LOAD: begin
            underrun   = ~bus.tx_valid_i;
            tx_shift_d = tx_word;
            miso_d     = fbo_q ? tx_word[DATA_WIDTH-1] : tx_word[0];
            bit_cnt_d  = '0;
            reload_d   = 1'b0;
            oe_d       = 1'b1;
            busy_d     = 1'b1;
            state_d    = SHIFT;
            if (ss_rise) begin
               miso_d  = 1'b0;
               oe_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               rx_shift_d = fbo_q ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == CW'(DATA_WIDTH-1)) begin
                  rx_data_d  = rx_shift_d;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  reload_d   = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (sck_fall) begin
               if (reload_q) begin
                  reload_d = 1'b0;
                  state_d  = LOAD;
               end else begin
                  tx_shift_d = fbo_q ? (tx_shift_q << 1) : (tx_shift_q >> 1);
                  miso_d     = fbo_q ? tx_shift_q[DATA_WIDTH-2] : tx_shift_q[1];
               end
            end
            // Deselect wins over a pending reload; a word completing this cycle still counts.
            if (ss_rise) begin
               abort    = (bit_cnt_d != '0);
               miso_d   = 1'b0;
               oe_d     = 1'b0;
               busy_d   = 1'b0;
               reload_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
      if (!spi_rst_i) begin
         state_q    <= IDLE;
         fbo_q      <= 1'b1;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         reload_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         fbo_q      <= fbo_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         reload_q   <= reload_d;
         rx_valid_q <= rx_valid_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

`ifdef SPI_ESCLAVO_ERRFLAG_EN
   logic [1:0] err_q, err_d;

   // Clear first so a same-cycle set survives.
   always_comb begin
      err_d = bus.err_clr_i ? 2'b00 : err_q;
      if (underrun) err_d[0] = 1'b1;
      if (abort)    err_d[1] = 1'b1;
   end

   always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
      if (!spi_rst_i) err_q <= 2'b00;
      else            err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   logic unused_err;
   assign unused_err = bus.err_clr_i ^ underrun ^ abort;
   assign bus.err_o  = 2'b00;
`endif

   assign MISO           = miso_q;
   assign miso_oe_o      = oe_q;
   assign bus.tx_ready_o = (state_q == LOAD);
   assign bus.rx_data_o  = rx_data_q;
   assign bus.rx_valid_o = rx_valid_q;
   assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_spi_esclavo.sv
// Scoreboard bench for spi_esclavo: stimulus queues expected rx/MISO words,
// independent monitors pop and compare as the DUT delivers them.
module tb_spi_esclavo;
   localparam int W    = 8;
   localparam int HALF = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sck   = 1'b0;
   logic ss    = 1'b1;
   logic mosi  = 1'b0;
   logic fbo   = 1'b1;
   logic miso, oe;

   spi_esclavo_if #(.DATA_WIDTH(W)) bus ();

   spi_esclavo #(.DATA_WIDTH(W)) dut (
      .spi_clk_i (clk),
      .spi_rst_i (rst_n),
      .SCK_SPI   (sck),
      .SS        (ss),
      .MOSI      (mosi),
      .MISO      (miso),
      .miso_oe_o (oe),
      .spi_fbo_i (fbo),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int           n_cmp     = 0;
   int           n_bad     = 0;
   int           ready_cnt = 0;
   bit           pop_pend  = 1'b0;
   logic [W-1:0] rx_exp[$];
   logic [W-1:0] miso_exp[$];
   logic [W-1:0] txq[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // tx supplier: a word is popped the cycle after the DUT's load strobe takes it.
   always @(negedge clk) begin
      if (pop_pend) begin
         void'(txq.pop_front());
         pop_pend = 1'b0;
      end
      if (bus.tx_ready_o === 1'b1) begin
         ready_cnt++;
         if (bus.tx_valid_i) pop_pend = 1'b1;
      end
      if (!pop_pend) begin
         bus.tx_valid_i = (txq.size() > 0);
         bus.tx_data_i  = (txq.size() > 0) ? txq[0] : '0;
      end
   end

   // rx monitor
   initial forever begin
      logic [W-1:0] e;
      @(negedge clk);
      if (bus.rx_valid_o === 1'b1) begin
         if (rx_exp.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_unexpected: got %0h expected no word", bus.rx_data_o);
         end else begin
            e = rx_exp.pop_front();
            check("rx_data", 32'(bus.rx_data_o), 32'(e));
         end
      end
   end

   // MISO monitor: samples at each SCK rise while driven, assembles in arrival order.
   initial begin
      int           mcnt  = 0;
      logic [W-1:0] mword = '0;
      logic [W-1:0] e;
      forever begin
         @(posedge sck or posedge ss);
         if (ss) mcnt = 0;
         else if (oe === 1'b1) begin
            mword = {mword[W-2:0], miso};
            mcnt++;
            if (mcnt == W) begin
               mcnt = 0;
               if (miso_exp.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL miso_unexpected: got %0h expected no word", mword);
               end else begin
                  e = miso_exp.pop_front();
                  check("miso_word", 32'(mword), 32'(e));
               end
            end
         end
      end
   end

   task automatic ss_begin(input bit msb);
      fbo = msb;
      ss  = 1'b0;
      wait_cyc(8);
   endtask

   task automatic spi_bits(input logic [W-1:0] w, input int n, input bit msb, input bit last);
      for (int i = 0; i < n; i++) begin
         mosi = msb ? w[W-1-i] : w[i];
         wait_cyc(HALF);
         sck = 1'b1;
         wait_cyc(HALF);
         sck = 1'b0;
         if (last && i == n - 1) ss = 1'b1;
      end
   endtask

   task automatic clear_err();
      bus.err_clr_i = 1'b1;
      wait_cyc(1);
      bus.err_clr_i = 1'b0;
      wait_cyc(1);
      check("err_cleared", 32'(bus.err_o), 32'd0);
   endtask

   initial begin
      bus.err_clr_i = 1'b0;
      wait_cyc(3);
      check("rst_miso",     32'(miso),           32'd0);
      check("rst_oe",       32'(oe),             32'd0);
      check("rst_ready",    32'(bus.tx_ready_o), 32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
      check("rst_rx_data",  32'(bus.rx_data_o),  32'd0);
      check("rst_busy",     32'(bus.busy_o),     32'd0);
      check("rst_err",      32'(bus.err_o),      32'd0);
      rst_n = 1'b1;
      wait_cyc(4);

      // MSB first
      txq.push_back(8'hA5); miso_exp.push_back(8'hA5); rx_exp.push_back(8'h3C);
      ss_begin(1'b1);
      check("busy_active", 32'(bus.busy_o), 32'd1);
      check("oe_active",   32'(oe),         32'd1);
      spi_bits(8'h3C, 8, 1'b1, 1'b1);
      wait_cyc(10);
      check("ready_msb", 32'(ready_cnt), 32'd1);
      check("busy_idle", 32'(bus.busy_o), 32'd0);

      // LSB first: 0x01 leaves as 1,0,..,0
      txq.push_back(8'h01); miso_exp.push_back(8'h80); rx_exp.push_back(8'h80);
      ss_begin(1'b0);
      spi_bits(8'h80, 8, 1'b0, 1'b1);
      wait_cyc(10);
      check("ready_lsb", 32'(ready_cnt), 32'd2);

      // back-to-back words in one select
      txq.push_back(8'h11); txq.push_back(8'h22);
      miso_exp.push_back(8'h11); miso_exp.push_back(8'h22);
      rx_exp.push_back(8'hDE); rx_exp.push_back(8'hAD);
      ss_begin(1'b1);
      spi_bits(8'hDE, 8, 1'b1, 1'b0);
      spi_bits(8'hAD, 8, 1'b1, 1'b1);
      wait_cyc(10);
      check("ready_b2b", 32'(ready_cnt), 32'd4);

      // underrun
      miso_exp.push_back(8'hFF); rx_exp.push_back(8'h5A);
      ss_begin(1'b1);
      spi_bits(8'h5A, 8, 1'b1, 1'b1);
      wait_cyc(10);
      check("ready_underrun", 32'(ready_cnt), 32'd5);
`ifdef SPI_ESCLAVO_ERRFLAG_EN
      check("err_underrun", 32'(bus.err_o), 32'd1);
`else
      check("err_underrun", 32'(bus.err_o), 32'd0);
`endif
      clear_err();

      // abort after 5 bits
      txq.push_back(8'h77);
      ss_begin(1'b1);
      spi_bits(8'hF0, 5, 1'b1, 1'b1);
      wait_cyc(10);
      check("abort_rx_data", 32'(bus.rx_data_o), 32'h5A);
      check("abort_busy",    32'(bus.busy_o),    32'd0);
      check("abort_oe",      32'(oe),            32'd0);
      check("ready_abort",   32'(ready_cnt),     32'd6);
`ifdef SPI_ESCLAVO_ERRFLAG_EN
      check("err_abort", 32'(bus.err_o), 32'd2);
`else
      check("err_abort", 32'(bus.err_o), 32'd0);
`endif
      clear_err();

      // reset mid-SHIFT, SS held low afterwards
      txq.push_back(8'h33);
      ss_begin(1'b1);
      spi_bits(8'hFF, 3, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_miso",    32'(miso),           32'd0);
      check("mid_rst_oe",      32'(oe),             32'd0);
      check("mid_rst_busy",    32'(bus.busy_o),     32'd0);
      check("mid_rst_rx_data", 32'(bus.rx_data_o),  32'd0);
      check("mid_rst_ready",   32'(bus.tx_ready_o), 32'd0);
      wait_cyc(2);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_cyc(HALF); sck = 1'b1;
         wait_cyc(HALF); sck = 1'b0;
      end
      check("post_rst_busy",  32'(bus.busy_o), 32'd0);
      check("post_rst_oe",    32'(oe),         32'd0);
      check("post_rst_ready", 32'(ready_cnt),  32'd7);
      ss = 1'b1;
      wait_cyc(10);

      // resumes after a fresh select
      txq.push_back(8'h96); miso_exp.push_back(8'h96); rx_exp.push_back(8'hC3);
      ss_begin(1'b1);
      spi_bits(8'hC3, 8, 1'b1, 1'b1);
      wait_cyc(10);
      check("ready_resume", 32'(ready_cnt), 32'd8);

      check("rx_left",   32'(rx_exp.size()),   32'd0);
      check("miso_left", 32'(miso_exp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_esclavo.md
# spi_esclavo

SPI slave responder for the Bootstrap SPI subsystem. It is the far end of the peripheral SPI link: it receives words that an SPI master clocks in on MOSI and returns words on MISO. It runs SPI mode 0 (CPOL=0, CPHA=0) and oversamples SCK_SPI, SS and MOSI on the system clock, so no logic runs on the SPI clock. Used to emulate peripherals in bench and FPGA bring-up, and as a slave port for an external controller.

## Interface
Parameters:
- DATA_WIDTH, 8, word length in bits (≥2)

Ports:
- spi_clk_i  in  1  system clock; all logic is rising-edge.
- spi_rst_i  in  1  asynchronous, active-low reset (0 = reset).
- SCK_SPI  in  1  SPI clock from the master; asynchronous.
- SS  in  1  slave select, active-low; asynchronous.
- MOSI  in  1  master data in; asynchronous.
- MISO  out  1  slave data out.
- miso_oe_o  out  1  MISO output enable; 1 while selected.
- spi_fbo_i  in  1  bit order, 1 = MSB first, 0 = LSB first; captured when SS falls.
- tx_data_i  in  DATA_WIDTH  next word to transmit.
- tx_valid_i  in  1  tx_data_i holds a word.
- tx_ready_o  out  1  one-cycle load strobe. The word is consumed if tx_valid_i=1 in that cycle.
- rx_data_o  out  DATA_WIDTH  last complete received word.
- rx_valid_o  out  1  one-cycle strobe; rx_data_o is new.
- busy_o  out  1  transaction in progress.
- err_o  out  2  sticky errors: [0] underrun, [1] abort. Present only with the macro (see Configuration).
- err_clr_i  in  1  clears err_o.

## Operation
- Synchronisers: SCK_SPI, SS and MOSI each pass through 2 flops. A third SCK and SS stage provides edge detection. Edges are acted on in the cycle after detection.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: MISO=0, miso_oe_o=0, busy_o=0.
  - On a synced SS fall, capture spi_fbo_i and go to LOAD.
- LOAD (1 cycle):
  - Assert tx_ready_o.
  - If tx_valid_i=1, tx_shift ← tx_data_i; otherwise tx_shift ← all ones and flag underrun.
  - Drive the first bit on MISO: bit DATA_WIDTH-1 if FBO=1, bit 0 if FBO=0.
  - Clear bit_cnt, set miso_oe_o=1 and busy_o=1, then go to SHIFT.
- SHIFT, SCK rise: shift the synced MOSI into rx_shift (MSB-first or LSB-first per FBO) and increment bit_cnt.
  - When bit_cnt reaches DATA_WIDTH: rx_data_o ← assembled word, pulse rx_valid_o, clear bit_cnt and set the reload pending flag.
- SHIFT, SCK fall:
  - If reload is pending, go to LOAD.
  - Otherwise shift tx_shift and drive the next bit on MISO.
- SS rise in SHIFT: return to IDLE.
  - If bit_cnt≠0, discard the partial word, keep rx_data_o unchanged, do not assert rx_valid_o, and flag abort.
- Simultaneous events:
  - If an SCK rise that completes a word and an SS rise are detected in the same cycle, the word completes (rx_valid_o=1). No abort is flagged.
  - In that case the FSM goes to IDLE, not LOAD.
- Reset asserted mid-transaction clears everything immediately. The FSM resumes only after the next SS fall.
- rx_data_o has no backpressure. A new word overwrites the previous one.

## Timing
- Reset values: MISO=0, miso_oe_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, err_o=0.
- Pin-to-action latency is 3 spi_clk_i cycles (2 sync + 1 detect).
- rx_valid_o asserts 3 cycles after the last SCK rise at the pin.
- MISO changes 3 cycles after an SCK fall at the pin, and 4 cycles after the SS fall for the first bit.
- Constraints: SCK_SPI high and low phases ≥ 4 spi_clk_i cycles each, so SCK ≤ spi_clk_i/8. SS setup to first SCK rise ≥ 5 cycles.

## Configuration
- SPI_ESCLAVO_ERRFLAG_EN defined:
  - err_o[0] sets on an underrun load; err_o[1] sets on abort.
  - Both bits are sticky until err_clr_i=1. If clear and set occur in the same cycle, set wins.
- Not defined: err_o is tied to 2'b00, err_clr_i is ignored, and no error registers are built. Data behaviour is identical.

## Test plan
- Reset: drive spi_rst_i=0 mid-SHIFT -> all outputs are at reset values immediately; the FSM stays in IDLE until the next SS fall.
- Mode 0, MSB first: tx_data_i=0xA5 with tx_valid_i=1, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a single rx_valid_o pulse; one tx_ready_o pulse.
- LSB first (spi_fbo_i=0): tx_data_i=0x01, master sends 0x80 LSB-first -> MISO shows 1 as the first bit; rx_data_o=0x80.
- Back-to-back: two bytes within one SS low; tx supplies 0x11 then 0x22; master sends 0xDE, 0xAD -> MISO returns 0x11, 0x22; rx_valid_o pulses twice with 0xDE then 0xAD.
- Underrun: tx_valid_i=0 at load -> MISO returns 0xFF; with the macro defined err_o=2'b01, cleared by err_clr_i.
- Abort: SS rises after 5 SCK bits -> no rx_valid_o, rx_data_o unchanged, FSM back in IDLE; with the macro defined err_o[1]=1.
